host_bus_ctrl: RTL and testbench

HOST_BUS_CTRL -- requirements
Module: host_bus_ctrl

---
 rtl/host_bus_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_host_bus_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/host_bus_ctrl.sv
// host_bus_ctrl -- CPU bus decoder and IO wait-state controller.
//
// Decodes a Z80-style bus into a RAM window and up to 16 IO devices. RAM
// reads and writes are passed straight through with one cycle of latency.
// IO accesses are stretched with nWAIT until the selected device signals
// ready or a timeout expires. Illegal bus states and IO timeouts raise a
// sticky error flag that only reset clears.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   A          CPU address bus
//   nMREQ, nIORQ, nRD, nWR, nM1   CPU bus controls (active-low)
//   io_ready   per-device ready (active-high)
//   ram_we     one-cycle RAM write pulse
//   ram_oe     RAM drives the CPU data bus
//   io_sel     one-hot selected IO device, held for the whole IO cycle
//   io_rd_stb  one-cycle IO read strobe
//   io_wr_stb  one-cycle IO write strobe
//   nWAIT      CPU wait request (active-low)
//   bus_err    sticky error flag
module host_bus_ctrl #(
  parameter int unsigned RAM_ADDR_BITS = 14,
  parameter int unsigned RAM_BASE      = 0,
  parameter int unsigned NUM_IO        = 4,
  parameter logic [7:0]  IO_BASE       = 8'h00,
  parameter int unsigned IO_TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       A,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic              nM1,
  input  logic [NUM_IO-1:0] io_ready,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [NUM_IO-1:0] io_sel,
  output logic              io_rd_stb,
  output logic              io_wr_stb,
  output logic              nWAIT,
  output logic              bus_err
);

  localparam int unsigned IDX_W     = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [8:0]  NUM_IO_W  = 9'(NUM_IO);
  localparam logic [7:0]  TIMEOUT_W = 8'(IO_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} stateT;

  // Live bus qualifiers
  logic memRd, memWr, ioRd, ioWr;
  logic ramHit, ioHit;
  logic [7:0] ioOffset;
  logic [IDX_W-1:0] devIdx;

  // Registered qualifiers and decode
  logic memRdQ, memWrQ, ioRdQ, ioWrQ;
  logic ramHitQ, ioHitQ;
  logic [IDX_W-1:0] devQ;
  logic [NUM_IO-1:0] readyQ;

  // Edge-arm flags: set only once the live qualifier has been seen low
  logic memWrArmed, ioArmed;

  stateT state, stateNext;
  logic [7:0] cnt, cntNext;
  logic [IDX_W-1:0] selReg, selNext;
  logic errReg, errSet;
  logic ioStart;
  logic ioAnyQ, illegalQ, readySel;

  logic unusedBits;

  assign memRd = !nMREQ && !nRD;
  assign memWr = !nMREQ && !nWR;
  assign ioRd  = !nIORQ && !nRD && nM1;
  assign ioWr  = !nIORQ && !nWR && nM1;

  generate
    if (RAM_ADDR_BITS >= 16) begin : gFullRam
      assign ramHit = 1'b1;
    end else begin : gRamWindow
      assign ramHit = (A[15:RAM_ADDR_BITS] == RAM_BASE[15-RAM_ADDR_BITS:0]);
    end
  endgenerate

  // 8-bit wrap-around: pages below IO_BASE land far above NUM_IO and miss
  assign ioOffset = A[15:8] - IO_BASE;
  assign ioHit    = ({1'b0, ioOffset} < NUM_IO_W);
  assign devIdx   = ioOffset[IDX_W-1:0];

  assign unusedBits = ^A[7:0];

  assign ioAnyQ   = ioRdQ || ioWrQ;
  assign illegalQ = (memRdQ || memWrQ) && ioAnyQ;
  assign readySel = readyQ[selReg];

  assign ram_oe = memRdQ && ramHitQ && !illegalQ;
  assign ram_we = memWrQ && ramHitQ && memWrArmed && !illegalQ;

  function automatic logic [NUM_IO-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [NUM_IO-1:0] v;
    for (int unsigned i = 0; i < NUM_IO; i++) begin
      v[i] = (idx == IDX_W'(i));
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      memRdQ     <= 1'b0;
      memWrQ     <= 1'b0;
      ioRdQ      <= 1'b0;
      ioWrQ      <= 1'b0;
      ramHitQ    <= 1'b0;
      ioHitQ     <= 1'b0;
      devQ       <= '0;
      readyQ     <= '0;
      memWrArmed <= 1'b0;
      ioArmed    <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      selReg     <= '0;
      errReg     <= 1'b0;
    end else begin
      memRdQ  <= memRd;
      memWrQ  <= memWr;
      ioRdQ   <= ioRd;
      ioWrQ   <= ioWr;
      ramHitQ <= ramHit;
      ioHitQ  <= ioHit;
      devQ    <= devIdx;
      readyQ  <= io_ready;
      // Arm flags start cleared so a cycle already in progress across
      // reset release is ignored until its qualifier drops.
      memWrArmed <= !memWr ? 1'b1 : (ram_we  ? 1'b0 : memWrArmed);
      ioArmed    <= !(ioRd || ioWr) ? 1'b1 : (ioStart ? 1'b0 : ioArmed);
      state      <= stateNext;
      cnt        <= cntNext;
      selReg     <= selNext;
      errReg     <= errReg || errSet;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    selNext   = selReg;
    nWAIT     = 1'b1;
    io_rd_stb = 1'b0;
    io_wr_stb = 1'b0;
    io_sel    = '0;
    ioStart   = 1'b0;
    errSet    = illegalQ;
    case (state)
      IDLE: begin
        if (ioAnyQ && ioHitQ && ioArmed && !illegalQ) begin
          ioStart   = 1'b1;
          stateNext = WAIT;
          cntNext   = '0;
          selNext   = devQ;
          nWAIT     = 1'b0;
          io_rd_stb = ioRdQ;
          io_wr_stb = ioWrQ;
          io_sel    = oneHot(devQ);
        end
      end
      WAIT: begin
        io_sel = oneHot(selReg);
        if (!ioAnyQ) begin
          stateNext = IDLE;
        end else if (readySel || (cnt == TIMEOUT_W)) begin
          stateNext = HOLD;
          errSet    = illegalQ || !readySel;
        end else begin
          cntNext = cnt + 8'd1;
          nWAIT   = 1'b0;
        end
      end
      HOLD: begin
        io_sel = oneHot(selReg);
        if (!ioAnyQ) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Error is visible in the cycle it is detected, then held by errReg
  assign bus_err = errReg || errSet;

endmodule

// File: tb/tb_host_bus_ctrl.sv
// tb_host_bus_ctrl -- randomized self-checking bench for host_bus_ctrl.
// Each bus transaction is described by kind, address, length and the cycle
// at which the device becomes ready; expected per-cycle outputs are derived
// arithmetically from those parameters.
module tb_host_bus_ctrl;

  localparam int T = 15;
  localparam int K_MRD  = 0;
  localparam int K_MWR  = 1;
  localparam int K_IORD = 2;
  localparam int K_IOWR = 3;
  localparam int K_INTA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] A;
  logic        nMREQ, nIORQ, nRD, nWR, nM1;
  logic [3:0]  io_ready;
  logic        ram_we, ram_oe;
  logic [3:0]  io_sel;
  logic        io_rd_stb, io_wr_stb, nWAIT, bus_err;

  int checks = 0;
  int errors = 0;
  bit errSticky = 1'b0;

  host_bus_ctrl #(
    .RAM_ADDR_BITS(14),
    .RAM_BASE     (0),
    .NUM_IO       (4),
    .IO_BASE      (8'h00),
    .IO_TIMEOUT   (T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .nMREQ    (nMREQ),
    .nIORQ    (nIORQ),
    .nRD      (nRD),
    .nWR      (nWR),
    .nM1      (nM1),
    .io_ready (io_ready),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .io_sel   (io_sel),
    .io_rd_stb(io_rd_stb),
    .io_wr_stb(io_wr_stb),
    .nWAIT    (nWAIT),
    .bus_err  (bus_err)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOuts(input string tag, input bit we, input bit oe, input logic [3:0] sel,
                           input bit rd, input bit wr, input bit nw, input bit err);
    checkVal({tag, ".ram_we"},    32'(ram_we),    32'(we));
    checkVal({tag, ".ram_oe"},    32'(ram_oe),    32'(oe));
    checkVal({tag, ".io_sel"},    32'(io_sel),    32'(sel));
    checkVal({tag, ".io_rd_stb"}, 32'(io_rd_stb), 32'(rd));
    checkVal({tag, ".io_wr_stb"}, 32'(io_wr_stb), 32'(wr));
    checkVal({tag, ".nWAIT"},     32'(nWAIT),     32'(nw));
    checkVal({tag, ".bus_err"},   32'(bus_err),   32'(err));
  endtask

  task automatic idleBus();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  // Inputs are driven at negedge; outputs are checked at the next negedge,
  // after the posedge that sampled them.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b0; idleBus(); A = 16'($urandom); io_ready = 4'($urandom);
    tick();
    checkOuts("reset", 0, 0, 4'b0, 0, 0, 1, 0);
    reset = 1'b1;
    tick();
    checkOuts("postreset", 0, 0, 4'b0, 0, 0, 1, 0);
    errSticky = 1'b0;
  endtask

  // One transaction of len bus cycles followed by two idle cycles. The
  // device becomes ready at cycle rdy. Exit from the wait happens at the
  // first sampled ready (never before cycle 1) or after T+1 cycles.
  task automatic runTxn(input int kind, input logic [15:0] addr, input int len, input int rdy);
    bit memHit, ioHitM, tmo;
    int page, exitP, lowEnd;
    memHit = (addr[15:14] == 2'b00);
    page   = int'(addr[15:8]);
    ioHitM = (page < 4) && (kind == K_IORD || kind == K_IOWR);
    exitP  = (rdy < 1) ? 1 : rdy;
    if (exitP > T + 1) exitP = T + 1;
    lowEnd = (exitP < len) ? exitP : len;
    tmo    = ioHitM && (rdy > T + 1) && (len > T + 1);
    for (int j = 0; j < len + 2; j++) begin
      bit inBus, expWe, expOe, expRd, expWr, expNw, expErr;
      logic [3:0] expSel;
      inBus = (j < len);
      idleBus();
      A = 16'($urandom);
      io_ready = 4'($urandom);
      if (inBus) begin
        A = addr;
        case (kind)
          K_MRD:  begin nMREQ = 1'b0; nRD = 1'b0; nM1 = 1'($urandom); end
          K_MWR:  begin nMREQ = 1'b0; nWR = 1'b0; nM1 = 1'($urandom); end
          K_IORD: begin nIORQ = 1'b0; nRD = 1'b0; end
          K_IOWR: begin nIORQ = 1'b0; nWR = 1'b0; end
          default: begin nIORQ = 1'b0; nM1 = 1'b0; nRD = 1'($urandom); end
        endcase
      end
      if (ioHitM) io_ready[page] = (j >= rdy);
      tick();
      expWe  = (kind == K_MWR) && memHit && (j == 0);
      expOe  = (kind == K_MRD) && memHit && inBus;
      expSel = (ioHitM && j <= len) ? 4'(1 << page) : 4'b0;
      expRd  = (kind == K_IORD) && ioHitM && (j == 0);
      expWr  = (kind == K_IOWR) && ioHitM && (j == 0);
      expNw  = !(ioHitM && j < lowEnd);
      expErr = errSticky || (tmo && j >= exitP);
      checkOuts($sformatf("txn k%0d a%04h c%0d", kind, addr, j),
                expWe, expOe, expSel, expRd, expWr, expNw, expErr);
    end
    if (tmo) errSticky = 1'b1;
  endtask

  initial begin
    logic [15:0] addr;
    int kind;

    reset = 1'b0; idleBus(); A = '0; io_ready = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOuts("initreset", 0, 0, 4'b0, 0, 0, 1, 0);
    end
    reset = 1'b1;
    tick();
    checkOuts("release", 0, 0, 4'b0, 0, 0, 1, 0);

    // Directed scenarios
    runTxn(K_MWR, 16'h1234, 4, 0);
    runTxn(K_MWR, 16'h4000, 4, 0);
    runTxn(K_IOWR, 16'h0200, 8, 3);
    runTxn(K_INTA, 16'h0000, 3, 0);
    runTxn(K_IORD, 16'h0100, 20, 99);
    if (errSticky) doReset();

    // Randomized transactions
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      if (kind == K_IORD || kind == K_IOWR) begin
        addr[15:8] = 8'($urandom_range(0, 7));
        addr[7:0]  = 8'($urandom);
      end else begin
        addr = 16'($urandom);
      end
      runTxn(kind, addr, $urandom_range(1, 22), $urandom_range(0, 24));
      if (errSticky) doReset();
    end

    // Reset during WAIT, released while the IO read is still on the bus
    for (int j = 0; j < 10; j++) begin
      idleBus(); A = 16'h0100; io_ready = 4'b0;
      if (j < 8) begin nIORQ = 1'b0; nRD = 1'b0; end
      reset = (j == 3) ? 1'b0 : 1'b1;
      tick();
      if (j < 3) checkOuts($sformatf("rstwait c%0d", j), 0, 0, 4'b0010, j == 0, 0, 0, errSticky);
      else       checkOuts($sformatf("rstwait c%0d", j), 0, 0, 4'b0, 0, 0, 1, 0);
    end
    errSticky = 1'b0;
    runTxn(K_IORD, 16'h0100, 3, 1);

    // Illegal: memory and IO requested together, error sticks until reset
    for (int j = 0; j < 4; j++) begin
      idleBus(); A = 16'h0100; io_ready = 4'b1111;
      if (j < 2) begin nMREQ = 1'b0; nIORQ = 1'b0; nRD = 1'b0; end
      tick();
      checkOuts($sformatf("illegal c%0d", j), 0, 0, 4'b0, 0, 0, 1, 1);
    end
    errSticky = 1'b1;
    runTxn(K_MWR, 16'h0010, 3, 0);
    runTxn(K_IOWR, 16'h0300, 4, 2);
    doReset();
    runTxn(K_MRD, 16'h0020, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
